// File: rtl/id_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : id_hazard_ctrl_if
// Description : ID-stage hazard control bundle between the pipeline and the
//               hazard controller.
// Revision    : 1.0
// ============================================================================
interface id_hazard_ctrl_if;
    logic       id_valid;
    logic [6:0] id_opcode;
    logic [6:0] id_func7;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [4:0] id_rd;
    logic       ex_redirect;
    logic       mem_stall;
    logic       stall_if;
    logic       stall_id;
    logic       flush_id;
    logic [1:0] fwd_rs1;
    logic [1:0] fwd_rs2;
    logic       md_start;
    logic       md_busy;

    modport master (
        output id_valid, id_opcode, id_func7, id_rs1, id_rs2, id_rd,
               ex_redirect, mem_stall,
        input  stall_if, stall_id, flush_id, fwd_rs1, fwd_rs2, md_start, md_busy
    );

    modport slave (
        input  id_valid, id_opcode, id_func7, id_rs1, id_rs2, id_rd,
               ex_redirect, mem_stall,
        output stall_if, stall_id, flush_id, fwd_rs1, fwd_rs2, md_start, md_busy
    );
endinterface
`default_nettype wire

// File: rtl/id_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : id_hazard_ctrl
// Description : ID-stage hazard controller: EX/MEM/WB destination tracking,
//               operand forwarding select, load-use / MUL-DIV stalls, flushes.
// Revision    : 1.0
// ============================================================================
module id_hazard_ctrl #(
    parameter int MD_LAT = 4
) (
    input  logic            clk,
    input  logic            rst,
    id_hazard_ctrl_if.slave bus
);

    localparam logic [6:0] c_OP_OP     = 7'b0110011;
    localparam logic [6:0] c_OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_OP32   = 7'b0111011;
    localparam logic [6:0] c_OP_OPIMM32= 7'b0011011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_F7_MEXT   = 7'b0000001;

    localparam int                 c_CNT_W    = (MD_LAT > 2) ? $clog2(MD_LAT - 1) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'((MD_LAT > 1) ? (MD_LAT - 2) : 0);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic               c_HAS_BUSY = (MD_LAT > 1);

    typedef enum logic [0:0] {
        S_RUN     = 1'b0,
        S_MD_BUSY = 1'b1
    } state_t;

    // EX entry carries load/M-ext flags; MEM/WB only need destination info.
    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       ld;
        logic       md;
    } ex_ent_t;

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
    } ent_t;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    ex_ent_t            r_e0;
    ent_t               r_e1;
    ent_t               r_e2;
    logic               r_e0_fresh;

    logic    w_writes_rd;
    logic    w_uses_rs1;
    logic    w_uses_rs2;
    logic    w_id_ld;
    logic    w_id_md;
    logic    w_load_use;
    logic    w_busy;
    logic    w_hold_ex;
    logic    w_stall;
    logic    w_flush;
    logic    w_issue;
    logic [1:0] w_fwd1;
    logic [1:0] w_fwd2;
    ex_ent_t w_new;

    function automatic logic f_match(input logic uses, input logic [4:0] rs,
                                     input logic v, input logic [4:0] rd);
        return uses && (rs != 5'd0) && v && (rd == rs);
    endfunction

    // A load in EX has no data yet, so it is skipped rather than forwarded.
    function automatic logic [1:0] f_src(input logic uses, input logic [4:0] rs,
                                         input ex_ent_t e0, input ent_t e1, input ent_t e2);
        if (f_match(uses, rs, e0.v, e0.rd) && !e0.ld) return 2'd1;
        if (f_match(uses, rs, e1.v, e1.rd))           return 2'd2;
        if (f_match(uses, rs, e2.v, e2.rd))           return 2'd3;
        return 2'd0;
    endfunction

    always_comb begin
        w_writes_rd = (bus.id_opcode inside {c_OP_OP, c_OP_OPIMM, c_OP_LOAD, c_OP_LUI,
                                             c_OP_AUIPC, c_OP_JAL, c_OP_JALR, c_OP_OP32,
                                             c_OP_OPIMM32}) && (bus.id_rd != 5'd0);
        w_uses_rs1  = !(bus.id_opcode inside {c_OP_LUI, c_OP_AUIPC, c_OP_JAL});
        w_uses_rs2  = bus.id_opcode inside {c_OP_OP, c_OP_OP32, c_OP_STORE, c_OP_BRANCH};
        w_id_ld     = (bus.id_opcode == c_OP_LOAD);
        w_id_md     = ((bus.id_opcode == c_OP_OP) || (bus.id_opcode == c_OP_OP32))
                      && (bus.id_func7 == c_F7_MEXT);
        w_new       = '{v: w_writes_rd, rd: bus.id_rd, ld: w_id_ld, md: w_id_md};
    end

    assign w_load_use = bus.id_valid && r_e0.v && r_e0.ld &&
                        (f_match(w_uses_rs1, bus.id_rs1, r_e0.v, r_e0.rd) ||
                         f_match(w_uses_rs2, bus.id_rs2, r_e0.v, r_e0.rd));
    assign w_fwd1     = f_src(w_uses_rs1, bus.id_rs1, r_e0, r_e1, r_e2);
    assign w_fwd2     = f_src(w_uses_rs2, bus.id_rs2, r_e0, r_e1, r_e2);
    assign w_busy     = (r_state == S_MD_BUSY);
    assign w_hold_ex  = w_busy && (r_cnt != '0);

    // Redirects are ignored while busy: EX then holds a non-branch M-ext op.
    always_comb begin
        w_stall = 1'b0;
        w_flush = 1'b0;
        if (bus.mem_stall)        w_stall = 1'b1;
        else if (w_busy)          w_stall = 1'b1;
        else if (bus.ex_redirect) w_flush = 1'b1;
        else if (w_load_use)      w_stall = 1'b1;
    end

    assign w_issue = bus.id_valid && !w_stall && !w_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_RUN;
            r_cnt      <= '0;
            r_e0       <= '0;
            r_e1       <= '0;
            r_e2       <= '0;
            r_e0_fresh <= 1'b0;
        end else if (!bus.mem_stall) begin
            if (w_hold_ex) begin
                r_e1       <= '0;
                r_e2       <= r_e1;
                r_cnt      <= r_cnt - c_CNT_ONE;
                r_e0_fresh <= 1'b0;
            end else begin
                r_e2       <= r_e1;
                r_e1       <= '{v: r_e0.v, rd: r_e0.rd};
                r_e0       <= w_issue ? w_new : '0;
                r_e0_fresh <= w_issue;
                if (w_issue && w_id_md && c_HAS_BUSY) begin
                    r_state <= S_MD_BUSY;
                    r_cnt   <= c_CNT_INIT;
                end else begin
                    r_state <= S_RUN;
                end
            end
        end
    end

    assign bus.stall_if = !rst && w_stall;
    assign bus.stall_id = !rst && w_stall;
    assign bus.flush_id = !rst && w_flush;
    assign bus.fwd_rs1  = rst ? 2'd0 : w_fwd1;
    assign bus.fwd_rs2  = rst ? 2'd0 : w_fwd2;
    assign bus.md_start = !rst && !bus.mem_stall && r_e0_fresh && r_e0.md;
    assign bus.md_busy  = !rst && w_busy;

endmodule
`default_nettype wire
